// File: rtl/int_seq_pkg.sv
// Shared types and constants for the interrupt sequencer.
// State encoding, source codes and vector low bytes.
package int_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DUMMY,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_P,
    ST_VEC_LO,
    ST_VEC_HI
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_IRQ  = 2'b01,
    SRC_NMI  = 2'b10,
    SRC_RES  = 2'b11
  } src_e;

  localparam logic [7:0] VEC_NMI = 8'hFA;
  localparam logic [7:0] VEC_RES = 8'hFC;
  localparam logic [7:0] VEC_IRQ = 8'hFE;

  function automatic logic [7:0] vec_lo(src_e s);
    logic [7:0] v;
    v = VEC_IRQ;
    case (s)
      SRC_RES: v = VEC_RES;
      SRC_NMI: v = VEC_NMI;
      default: v = VEC_IRQ;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/int_sequencer_pin_sync.sv
// Two-flop pin synchronizer, inactive level 1,
// with an optional falling-edge strobe on the synced value.
module pin_sync_edge #(
  parameter bit EDGE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic sync_o,
  output logic fall_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = pin_i;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign sync_o = s2_q;

  generate
    if (EDGE_EN) begin : g_edge
      logic d_q, d_d;

      always_comb d_d = s2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b1;
        else        d_q <= d_d;
      end

      assign fall_o = d_q & ~s2_q;
    end else begin : g_no_edge
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/int_sequencer.sv
// Interrupt/reset entry sequencer: arbitrates RES/NMI/IRQ/BRK
// at instruction boundaries and walks the 6-cycle push/vector sequence.
module int_sequencer
  import int_seq_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SYNC,
  input  logic       RDY,
  input  logic       RES_N,
  input  logic       NMI_N,
  input  logic       IRQ_N,
  input  logic       BRK_REQ,
  input  logic       I_FLAG,
  output logic       BUSY,
  output logic [1:0] SRC,
  output logic       RW,
  output logic       S_ADL_EN,
  output logic       S_DEC,
  output logic       PCH_DB_EN,
  output logic       PCL_DB_EN,
  output logic       PSR_DB_EN,
  output logic       B_FLAG,
  output logic       VEC_EN,
  output logic [7:0] VEC_ADL,
  output logic       PCL_LOAD_DB,
  output logic       PCH_LOAD_DB,
  output logic       I_SET,
  output logic       DONE
);

  state_e state_q, state_d;
  src_e   src_q, src_d;
  logic   brk_q, brk_d;
  logic   nmi_pend_q, nmi_pend_d;
  logic   res_pend_q, res_pend_d;

  logic nmi_sync, nmi_fall;
  logic irq_sync, irq_fall_unused;
  logic res_sync, res_fall_unused;
  logic irq_req, in_push;

  pin_sync_edge #(.EDGE_EN(1'b1)) u_nmi_sync (
    .clk    (CLK),
    .rst_n  (RST_N),
    .pin_i  (NMI_N),
    .sync_o (nmi_sync),
    .fall_o (nmi_fall)
  );

  pin_sync_edge #(.EDGE_EN(1'b0)) u_irq_sync (
    .clk    (CLK),
    .rst_n  (RST_N),
    .pin_i  (IRQ_N),
    .sync_o (irq_sync),
    .fall_o (irq_fall_unused)
  );

  pin_sync_edge #(.EDGE_EN(1'b0)) u_res_sync (
    .clk    (CLK),
    .rst_n  (RST_N),
    .pin_i  (RES_N),
    .sync_o (res_sync),
    .fall_o (res_fall_unused)
  );

  assign irq_req = ~irq_sync & ~I_FLAG;
  assign in_push = (state_q == ST_PUSH_PCH) ||
                   (state_q == ST_PUSH_PCL) ||
                   (state_q == ST_PUSH_P);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_NONE;
      brk_q      <= 1'b0;
      nmi_pend_q <= 1'b0;
      res_pend_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      brk_q      <= brk_d;
      nmi_pend_q <= nmi_pend_d;
      res_pend_q <= res_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    brk_d      = brk_q;
    nmi_pend_d = nmi_pend_q;
    res_pend_d = res_pend_q;

    unique case (state_q)
      ST_IDLE: begin
        if (res_pend_q) begin
          state_d = ST_DUMMY;
          src_d   = SRC_RES;
          brk_d   = 1'b0;
        end else if (SYNC) begin
          if (nmi_pend_q) begin
            state_d = ST_DUMMY;
            src_d   = SRC_NMI;
          end else if (irq_req) begin
            state_d = ST_DUMMY;
            src_d   = SRC_IRQ;
          end else if (BRK_REQ) begin
            state_d = ST_DUMMY;
            src_d   = SRC_IRQ;
            brk_d   = 1'b1;
          end
        end
      end
      ST_DUMMY:    if (RDY) state_d = ST_PUSH_PCH;
      ST_PUSH_PCH: state_d = ST_PUSH_PCL;
      ST_PUSH_PCL: state_d = ST_PUSH_P;
      ST_PUSH_P:   state_d = ST_VEC_LO;
      ST_VEC_LO:   if (RDY) state_d = ST_VEC_HI;
      ST_VEC_HI: begin
        if (RDY) begin
          state_d = ST_IDLE;
          src_d   = SRC_NONE;
          brk_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A late NMI steals an IRQ/BRK sequence; brk_q keeps the pushed B bit
    if (in_push && src_q == SRC_IRQ && nmi_pend_q)
      src_d = SRC_NMI;

    if (state_q == ST_PUSH_P) begin
      res_pend_d = 1'b0;
      if (src_d == SRC_NMI) nmi_pend_d = 1'b0;
    end

    if (nmi_fall) nmi_pend_d = 1'b1;

    if (!res_sync) begin
      state_d    = ST_IDLE;
      src_d      = SRC_NONE;
      brk_d      = 1'b0;
      res_pend_d = 1'b1;
    end
  end

  always_comb begin
    BUSY        = (state_q != ST_IDLE);
    SRC         = src_q;
    RW          = 1'b1;
    S_ADL_EN    = 1'b0;
    S_DEC       = 1'b0;
    PCH_DB_EN   = 1'b0;
    PCL_DB_EN   = 1'b0;
    PSR_DB_EN   = 1'b0;
    B_FLAG      = 1'b0;
    VEC_EN      = 1'b0;
    VEC_ADL     = 8'h00;
    PCL_LOAD_DB = 1'b0;
    PCH_LOAD_DB = 1'b0;
    I_SET       = 1'b0;
    DONE        = 1'b0;

    if (in_push) begin
      S_ADL_EN = 1'b1;
      S_DEC    = 1'b1;
      RW       = (src_q == SRC_RES);
    end

    unique case (state_q)
      ST_PUSH_PCH: PCH_DB_EN = 1'b1;
      ST_PUSH_PCL: PCL_DB_EN = 1'b1;
      ST_PUSH_P: begin
        PSR_DB_EN = 1'b1;
        B_FLAG    = brk_q;
      end
      ST_VEC_LO: begin
        VEC_EN      = 1'b1;
        VEC_ADL     = vec_lo(src_q);
        PCL_LOAD_DB = 1'b1;
        I_SET       = 1'b1;
      end
      ST_VEC_HI: begin
        VEC_EN      = 1'b1;
        VEC_ADL     = vec_lo(src_q) + 8'd1;
        PCH_LOAD_DB = 1'b1;
        DONE        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer with a sequence-level
// reference model checked every cycle.
module tb_int_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N, SYNC, RDY, RES_N, NMI_N, IRQ_N;
  logic       BRK_REQ, I_FLAG;
  logic       BUSY, RW, S_ADL_EN, S_DEC;
  logic       PCH_DB_EN, PCL_DB_EN, PSR_DB_EN, B_FLAG;
  logic       VEC_EN, PCL_LOAD_DB, PCH_LOAD_DB, I_SET, DONE;
  logic [1:0] SRC;
  logic [7:0] VEC_ADL;

  int n_chk  = 0;
  int n_fail = 0;

  int cap_adl[16], cap_rw[16], cap_b[16];
  int cap_sdec[16], cap_src[16], cap_done[16];

  always #5 CLK = ~CLK;

  int_sequencer dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .SYNC        (SYNC),
    .RDY         (RDY),
    .RES_N       (RES_N),
    .NMI_N       (NMI_N),
    .IRQ_N       (IRQ_N),
    .BRK_REQ     (BRK_REQ),
    .I_FLAG      (I_FLAG),
    .BUSY        (BUSY),
    .SRC         (SRC),
    .RW          (RW),
    .S_ADL_EN    (S_ADL_EN),
    .S_DEC       (S_DEC),
    .PCH_DB_EN   (PCH_DB_EN),
    .PCL_DB_EN   (PCL_DB_EN),
    .PSR_DB_EN   (PSR_DB_EN),
    .B_FLAG      (B_FLAG),
    .VEC_EN      (VEC_EN),
    .VEC_ADL     (VEC_ADL),
    .PCL_LOAD_DB (PCL_LOAD_DB),
    .PCH_LOAD_DB (PCH_LOAD_DB),
    .I_SET       (I_SET),
    .DONE        (DONE)
  );

  // Model: step 0 = idle, 1..6 = position in the entry sequence.
  // Pin histories hold the last three samples, [0] newest.
  typedef struct packed {
    logic [2:0] step;
    logic [1:0] src;
    logic       brk;
    logic       nmi_p;
    logic       res_p;
    logic [2:0] nh;
    logic [2:0] ih;
    logic [2:0] rh;
  } model_t;

  localparam model_t M_RST = '{
    step: 3'd0, src: 2'd0, brk: 1'b0,
    nmi_p: 1'b0, res_p: 1'b1,
    nh: 3'b111, ih: 3'b111, rh: 3'b111
  };

  model_t m;

  function automatic model_t model_next(
    model_t c, logic sync, logic rdy, logic res_n,
    logic nmi_n, logic irq_n, logic brk, logic iflag
  );
    model_t n;
    logic   fall, stall;
    n    = c;
    n.nh = {c.nh[1:0], nmi_n};
    n.ih = {c.ih[1:0], irq_n};
    n.rh = {c.rh[1:0], res_n};
    fall  = c.nh[2] & ~c.nh[1];
    stall = !rdy && (c.step == 3'd1 || c.step >= 3'd5);
    if (!c.rh[1]) begin
      n.step  = 3'd0;
      n.src   = 2'd0;
      n.brk   = 1'b0;
      n.res_p = 1'b1;
    end else if (c.step == 3'd0) begin
      if (c.res_p) begin
        n.step = 3'd1;
        n.src  = 2'd3;
        n.brk  = 1'b0;
      end else if (sync) begin
        if (c.nmi_p) begin
          n.step = 3'd1;
          n.src  = 2'd2;
        end else if (!c.ih[1] && !iflag) begin
          n.step = 3'd1;
          n.src  = 2'd1;
        end else if (brk) begin
          n.step = 3'd1;
          n.src  = 2'd1;
          n.brk  = 1'b1;
        end
      end
    end else begin
      if (c.step >= 3'd2 && c.step <= 3'd4 &&
          c.src == 2'd1 && c.nmi_p)
        n.src = 2'd2;
      if (!stall)
        n.step = (c.step == 3'd6) ? 3'd0 : 3'(c.step + 3'd1);
      if (c.step == 3'd4) begin
        n.res_p = 1'b0;
        if (n.src == 2'd2) n.nmi_p = 1'b0;
      end
      if (c.step == 3'd6 && !stall) begin
        n.src = 2'd0;
        n.brk = 1'b0;
      end
    end
    if (fall) n.nmi_p = 1'b1;
    return n;
  endfunction

  function automatic logic [22:0] exp_vec(model_t c);
    logic [7:0] v, adl;
    logic       push;
    v = (c.src == 2'd3) ? 8'hFC :
        (c.src == 2'd2) ? 8'hFA : 8'hFE;
    push = (c.step >= 3'd2 && c.step <= 3'd4);
    adl  = (c.step == 3'd5) ? v :
           (c.step == 3'd6) ? v + 8'd1 : 8'h00;
    return {c.step != 3'd0, c.src,
            !(push && c.src != 2'd3),
            push, push,
            c.step == 3'd2, c.step == 3'd3, c.step == 3'd4,
            c.step == 3'd4 && c.brk,
            c.step >= 3'd5, adl,
            c.step == 3'd5, c.step == 3'd6,
            c.step == 3'd5, c.step == 3'd6};
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) m <= M_RST;
    else m <= model_next(m, SYNC, RDY, RES_N,
                         NMI_N, IRQ_N, BRK_REQ, I_FLAG);
  end

  logic [22:0] dut_vec;
  assign dut_vec = {BUSY, SRC, RW, S_ADL_EN, S_DEC,
                    PCH_DB_EN, PCL_DB_EN, PSR_DB_EN, B_FLAG,
                    VEC_EN, VEC_ADL, PCL_LOAD_DB, PCH_LOAD_DB,
                    I_SET, DONE};

  initial begin
    forever begin
      @(negedge CLK);
      n_chk++;
      if (dut_vec !== exp_vec(m)) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t dut=%h model=%h",
                 $time, dut_vec, exp_vec(m));
      end
    end
  end

  task automatic chk(string name, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_sync();
    SYNC = 1'b1;
    @(negedge CLK);
    SYNC = 1'b0;
  endtask

  task automatic quiet(string name, int n);
    int b;
    b = 0;
    repeat (n) begin
      b += int'(BUSY);
      @(negedge CLK);
    end
    chk(name, b, 0);
  endtask

  // Records one sequence from its first busy cycle to DONE.
  task automatic capture(output int len);
    int w;
    len = 0;
    w   = 0;
    for (int i = 0; i < 16; i++) begin
      cap_adl[i] = 0; cap_rw[i] = 0; cap_b[i] = 0;
      cap_sdec[i] = 0; cap_src[i] = 0; cap_done[i] = 0;
    end
    while (!BUSY && w < 20) begin
      @(negedge CLK);
      w++;
    end
    chk("seq_start", int'(BUSY), 1);
    if (!BUSY) return;
    for (int i = 0; i < 16; i++) begin
      cap_adl[i]  = int'(VEC_ADL);
      cap_rw[i]   = int'(RW);
      cap_b[i]    = int'(B_FLAG);
      cap_sdec[i] = int'(S_DEC);
      cap_src[i]  = int'(SRC);
      cap_done[i] = int'(DONE);
      len = i + 1;
      if (DONE) break;
      @(negedge CLK);
    end
  endtask

  task automatic stall_vec_lo();
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (I_SET) begin
        RDY = 1'b0;
        repeat (3) @(negedge CLK);
        RDY = 1'b1;
        break;
      end
    end
    RDY = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    RST_N = 1'b0; RES_N = 1'b1; NMI_N = 1'b1; IRQ_N = 1'b1;
    SYNC = 1'b0; RDY = 1'b1; BRK_REQ = 1'b0; I_FLAG = 1'b0;
    tick(2);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_rw", int'(RW), 1);
    chk("rst_adl", int'(VEC_ADL), 0);
    chk("rst_src", int'(SRC), 0);

    // power-on reset sequence
    RST_N = 1'b1;
    capture(len);
    chk("por_len", len, 6);
    chk("por_src", cap_src[0], 3);
    chk("por_rw", cap_rw[1] + cap_rw[2] + cap_rw[3], 3);
    chk("por_sdec", cap_sdec[1] + cap_sdec[2] + cap_sdec[3], 3);
    chk("por_adl_lo", cap_adl[4], 'hFC);
    chk("por_adl_hi", cap_adl[5], 'hFD);
    chk("por_done", cap_done[5], 1);
    @(negedge CLK);
    chk("por_idle", int'(BUSY), 0);

    // IRQ taken, then masked
    IRQ_N = 1'b0;
    tick(3);
    pulse_sync();
    capture(len);
    chk("irq_len", len, 6);
    chk("irq_src", cap_src[0], 1);
    chk("irq_rw", cap_rw[1] + cap_rw[2] + cap_rw[3], 0);
    chk("irq_b", cap_b[3], 0);
    chk("irq_adl_lo", cap_adl[4], 'hFE);
    chk("irq_adl_hi", cap_adl[5], 'hFF);
    IRQ_N = 1'b1;
    tick(3);
    I_FLAG = 1'b1;
    IRQ_N  = 1'b0;
    tick(3);
    pulse_sync();
    quiet("irq_masked", 5);
    IRQ_N  = 1'b1;
    I_FLAG = 1'b0;
    tick(3);

    // IRQ beats BRK; then BRK alone
    IRQ_N   = 1'b0;
    BRK_REQ = 1'b1;
    tick(3);
    pulse_sync();
    BRK_REQ = 1'b0;
    capture(len);
    chk("irq_brk_b", cap_b[3], 0);
    IRQ_N = 1'b1;
    tick(3);
    BRK_REQ = 1'b1;
    pulse_sync();
    BRK_REQ = 1'b0;
    capture(len);
    chk("brk_b", cap_b[3], 1);
    chk("brk_src", cap_src[0], 1);
    chk("brk_adl", cap_adl[4], 'hFE);
    tick(2);

    // NMI hijacks a BRK sequence
    BRK_REQ = 1'b1;
    SYNC    = 1'b1;
    @(negedge CLK);
    SYNC    = 1'b0;
    BRK_REQ = 1'b0;
    NMI_N   = 1'b0;
    capture(len);
    chk("hij_len", len, 6);
    chk("hij_b", cap_b[3], 1);
    chk("hij_src", cap_src[4], 2);
    chk("hij_adl_lo", cap_adl[4], 'hFA);
    chk("hij_adl_hi", cap_adl[5], 'hFB);
    NMI_N = 1'b1;
    tick(3);
    pulse_sync();
    quiet("nmi_cleared", 5);

    // RDY stall in VEC_LO
    IRQ_N = 1'b0;
    tick(3);
    pulse_sync();
    fork
      capture(len);
      stall_vec_lo();
    join
    chk("stall_len", len, 9);
    for (int i = 4; i < 8; i++)
      chk("stall_adl_held", cap_adl[i], 'hFE);
    chk("stall_adl_hi", cap_adl[8], 'hFF);
    IRQ_N = 1'b1;
    tick(3);

    // external reset aborts in PUSH_PCL
    IRQ_N = 1'b0;
    tick(3);
    SYNC = 1'b1;
    @(negedge CLK);
    SYNC  = 1'b0;
    RES_N = 1'b0;
    tick(2);
    chk("abort_pcl", int'(PCL_DB_EN), 1);
    @(negedge CLK);
    chk("abort_idle", int'(BUSY), 0);
    IRQ_N = 1'b1;
    quiet("res_held", 3);
    RES_N = 1'b1;
    capture(len);
    chk("res_len", len, 6);
    chk("res_src", cap_src[0], 3);
    chk("res_rw", cap_rw[1] + cap_rw[2] + cap_rw[3], 3);
    chk("res_adl", cap_adl[4], 'hFC);
    @(negedge CLK);
    chk("res_idle", int'(BUSY), 0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/int_sequencer.md
INT_SEQUENCER -- requirements
Module: int_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low: CLK  in  1  system clock, all state on rising edge.
REQ-002 RST_N  in  1  asynchronous active-low reset.
REQ-003 SYNC  in  1  instruction-boundary strobe from timing logic; arbitration happens only when it is high.
REQ-004 RDY  in  1  bus-ready; 0 stalls read cycles.
REQ-005 RES_N, NMI_N, IRQ_N  in  1 each  external reset, NMI and IRQ request pins, all active-low and asynchronous to CLK.
REQ-006 BRK_REQ  in  1  decoder flags BRK opcode at boundary.
REQ-007 I_FLAG  in  1  PSR bit 2, the interrupt mask.
REQ-008 BUSY  out  1  high in every non-IDLE state.
REQ-009 SRC  out  2  active source: 00 none, 01 IRQ, 10 NMI, 11 RES; BRK reports 01 with B_FLAG=1.
REQ-010 RW  out  1  1=read, 0=write.
REQ-011 S_ADL_EN, S_DEC  out  1 each  put stack pointer on ADL; decrement S.
REQ-012 PCH_DB_EN, PCL_DB_EN, PSR_DB_EN  out  1 each  drive PCH, PCL or PSR onto DB.
REQ-013 B_FLAG  out  1  value of pushed P bit 4.
REQ-014 VEC_EN  out  1; VEC_ADL  out  8  force ADH=FF with ADL=VEC_ADL.
REQ-015 PCL_LOAD_DB, PCH_LOAD_DB, I_SET  out  1 each  load PC bytes from DB; set the I flag.
REQ-016 DONE  out  1  one-cycle pulse on the last sequence cycle.

Function
REQ-017 The FSM SHALL have the states IDLE, DUMMY, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI; every other state advances one step per clock in the order listed.
REQ-018 Outputs SHALL be Moore-decoded from the state and source registers; an output not listed for a state SHALL be 0, and RW SHALL be 1.
REQ-019 DUMMY: RW=1 and no enables asserted.
REQ-020 PUSH_PCH, PUSH_PCL and PUSH_P: S_ADL_EN=1, S_DEC=1 and RW=0, with PCH_DB_EN, PCL_DB_EN and PSR_DB_EN respectively asserted.
REQ-021 Source RES: RW SHALL stay 1 in the push states, so writes are suppressed while S still decrements.
REQ-022 PUSH_P: B_FLAG=1 for BRK and 0 for all other sources.
REQ-023 VEC_LO: VEC_EN=1, VEC_ADL=vector low byte, PCL_LOAD_DB=1 and I_SET=1.
REQ-024 VEC_HI: VEC_EN=1, VEC_ADL=vector low byte + 1, PCH_LOAD_DB=1 and DONE=1; the next state is IDLE.
REQ-025 Vector low bytes: RES FC, NMI FA, IRQ/BRK FE.
REQ-026 IDLE with SYNC=1: the source SHALL be chosen by priority RES pending > NMI pending > IRQ (synced IRQ_N low and I_FLAG=0) > BRK_REQ; the FSM enters DUMMY on the next edge; with no request it stays in IDLE.
REQ-027 NMI_N and IRQ_N SHALL each pass through a 2-flop synchronizer.
REQ-028 A falling edge of synced NMI SHALL set nmi_pending; a held-low NMI_N SHALL not retrigger.
REQ-029 nmi_pending SHALL clear when VEC_LO is entered with SRC=NMI.
REQ-030 IRQ SHALL be level-sensitive and not latched; if it is released before the boundary, no IRQ sequence SHALL run.
REQ-031 NMI hijack: if nmi_pending is set while in PUSH_PCH, PUSH_PCL or PUSH_P with source IRQ or BRK, the source SHALL change to NMI before VEC_LO; B_FLAG, already decided at PUSH_P, SHALL be unchanged.
REQ-032 RDY=0 in DUMMY, VEC_LO or VEC_HI SHALL hold the state and outputs.
REQ-033 RDY SHALL be ignored in the push states.
REQ-034 Synced RES_N low SHALL force IDLE in the next cycle from any state (abort) and set res_pending.
REQ-035 On synced RES_N high with res_pending set, the FSM SHALL enter DUMMY on the next edge without waiting for SYNC.
REQ-036 res_pending SHALL clear on entering VEC_LO.
REQ-037 A complete sequence SHALL take 6 cycles from DUMMY through VEC_HI, excluding RDY stalls.

Reset
REQ-038 While RST_N=0: state=IDLE, nmi_pending=0, and res_pending=1 so that a power-on reset sequence runs once RES_N is high.
REQ-039 During reset: SRC=00 and RW=1; all other outputs 0, including VEC_ADL=00.
REQ-040 Synchronizer flops SHALL reset to 1, the inactive level.

Structure
REQ-041 A shared package int_seq_pkg SHALL hold the state enum, the SRC encoding, and the vector constants FA, FC, FE.
REQ-042 One sub-module, pin_sync_edge, SHALL provide the 2-flop synchronizer with an optional falling-edge detect; it SHALL be instantiated for NMI, IRQ and RES.

Verification
REQ-043 Release RST_N with RES_N=1 -> DUMMY, then 3 push cycles with RW=1 and S_DEC=1, then VEC_ADL=FC then FD, DONE pulse, SRC=11.
REQ-044 IRQ_N=0, I_FLAG=0, SYNC pulse -> pushes with RW=0, B_FLAG=0, VEC_ADL FE then FF; repeat with I_FLAG=1 -> BUSY stays 0.
REQ-045 BRK_REQ and IRQ both at SYNC -> IRQ wins (B_FLAG=0); BRK_REQ alone -> B_FLAG=1 in PUSH_P.
REQ-046 BRK sequence with NMI_N falling 2 cycles after entering DUMMY -> B_FLAG=1, vectors FA then FB, and nmi_pending cleared after VEC_LO.
REQ-047 RDY=0 for 3 cycles in VEC_LO -> VEC_ADL held at FE, total sequence length 9 cycles.
REQ-048 RES_N low during PUSH_PCL -> IDLE next cycle; on RES_N high -> full RES sequence with VEC_ADL FC.
